des_key_schedule: RTL

- Round-key generator that sits directly downstream of the round-control state machine.
- Consumes that controller's per-round mux selects, Select_mux_pc_temp (load via PC-1) and Select_mux_shift_temp (advance one round).
- Holds the 28-bit C/D key halves, rotates them per the DES shift table, and presents a registered 48-bit PC-2 round key to the Feistel datapath.
- Supports encryption order (K1..K16) and decryption order (K16..K1).

---
 rtl/des_key_schedule.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/des_key_schedule.sv
// DES round-key generator: holds the C/D key halves, rotates them per the DES
// shift table in encryption or decryption order and registers the PC-2 round key.
module des_key_schedule #(
    parameter int NUM_ROUNDS = 16
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [63:0] Key_in,
    input  logic        Decrypt,
    input  logic        Select_mux_pc_temp,
    input  logic        Select_mux_shift_temp,
    output logic [47:0] Round_key,
    output logic [4:0]  Round_num,
    output logic        Key_valid,
    output logic        Done,
    output logic        Shift_err
);

    localparam logic [4:0] LAST_ROUND = 5'(NUM_ROUNDS);

    // Tables hold 1-based DES bit numbers; bit 1 is the MSB of the source word.
    localparam int PC1_TBL [0:55] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2_TBL [0:47] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    function automatic logic [55:0] pc1(input logic [63:0] k);
        logic [55:0] r;
        r = '0;
        for (int i = 0; i < 56; i++) begin
            r[55-i] = k[64-PC1_TBL[i]];
        end
        return r;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0] r;
        r = '0;
        for (int i = 0; i < 48; i++) begin
            r[47-i] = cd[56-PC2_TBL[i]];
        end
        return r;
    endfunction

    // Shift amount S[r] of the DES schedule: rounds 1, 2, 9 and 16 shift by one.
    function automatic logic shift_is_one(input logic [4:0] r);
        return (r == 5'd1) || (r == 5'd2) || (r == 5'd9) || (r == 5'd16);
    endfunction

    function automatic logic [27:0] rotl(input logic [27:0] x, input logic one);
        return one ? {x[26:0], x[27]} : {x[25:0], x[27:26]};
    endfunction

    function automatic logic [27:0] rotr(input logic [27:0] x, input logic one);
        return one ? {x[0], x[27:1]} : {x[1:0], x[27:2]};
    endfunction

    logic [27:0] c_q, c_d, d_q, d_d;
    logic [47:0] key_q, key_d;
    logic [4:0]  round_q, round_d;
    logic        valid_q, valid_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        mode_q, mode_d;
    logic [55:0] cd0;

    assign cd0 = pc1(Key_in);

    always_comb begin
        c_d     = c_q;
        d_d     = d_q;
        key_d   = key_q;
        round_d = round_q;
        valid_d = 1'b0;
        err_d   = err_q;
        mode_d  = mode_q;
        if (Select_mux_pc_temp) begin
            mode_d  = Decrypt;
            round_d = 5'd1;
            err_d   = 1'b0;
            valid_d = 1'b1;
            // Decryption starts at K16, whose 28 cumulative shifts land back on C0/D0.
            if (Decrypt) begin
                c_d = cd0[55:28];
                d_d = cd0[27:0];
            end else begin
                c_d = rotl(cd0[55:28], 1'b1);
                d_d = rotl(cd0[27:0], 1'b1);
            end
            key_d = pc2({c_d, d_d});
        end else if (Select_mux_shift_temp) begin
            if (round_q == 5'd0 || round_q == LAST_ROUND) begin
                err_d = 1'b1;
            end else begin
                round_d = round_q + 5'd1;
                valid_d = 1'b1;
                if (mode_q) begin
                    c_d = rotr(c_q, shift_is_one(5'd18 - round_d));
                    d_d = rotr(d_q, shift_is_one(5'd18 - round_d));
                end else begin
                    c_d = rotl(c_q, shift_is_one(round_d));
                    d_d = rotl(d_q, shift_is_one(round_d));
                end
                key_d = pc2({c_d, d_d});
            end
        end
        done_d = (round_d == LAST_ROUND);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            c_q     <= '0;
            d_q     <= '0;
            key_q   <= '0;
            round_q <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            mode_q  <= 1'b0;
        end else begin
            c_q     <= c_d;
            d_q     <= d_d;
            key_q   <= key_d;
            round_q <= round_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            err_q   <= err_d;
            mode_q  <= mode_d;
        end
    end

    assign Round_key = key_q;
    assign Round_num = round_q;
    assign Key_valid = valid_q;
    assign Done      = done_q;
    assign Shift_err = err_q;

endmodule
